alu_sequencer: RTL and testbench

- Parametrised successor to the board-level operand-mux/ALU controller: a WIDTH-bit ALU with a button-driven operand-entry FSM.
- Adds iterative multiply/divide, status flags, a busy/done handshake and accumulator chaining.
- Sits between switch/button inputs, the LED operand display and the seven-segment result path, clocked by the divided clock.

---
 rtl/alu_seq_pkg.sv | 36 +++
 rtl/alu_iter_muldiv.sv | 69 ++++++
 rtl/alu_sequencer.sv | 174 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for alu_sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_ASR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_DIV = 4'd10;
  localparam logic [3:0] OP_SLT = 4'd11;

  typedef enum logic [2:0] {
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_ITER,
    S_SHOW
  } state_t;

  localparam int F_Z  = 0;
  localparam int F_C  = 1;
  localparam int F_V  = 2;
  localparam int F_N  = 3;
  localparam int F_DZ = 4;

  // Ops that run through the shift-add / restoring-divide unit.
  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// WIDTH-step iterative unit: unsigned shift-add multiply or restoring divide.
// lo/hi present the register contents *after* the step taken on the coming
// edge, so the caller captures the final result on the edge where last=1.
module alu_iter_muldiv import alu_seq_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             last,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic             div_q;
  logic [WIDTH-1:0] lo_q, hi_q, opb_q;
  logic [WIDTH:0]   sum, shifted, diff;
  logic             ge;

  // One step: mul adds the multiplicand into the high word and shifts the
  // pair right; div shifts the dividend bit into the remainder and subtracts.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, opb_q};
    ge      = (shifted >= {1'b0, opb_q});
    if (div_q) begin
      hi = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      lo = {lo_q[WIDTH-2:0], ge};
    end else begin
      hi = sum[WIDTH:1];
      lo = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign last = busy && (cnt == '0);

  // Load operands on start, then advance one step per cycle for WIDTH cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy  <= 1'b0;
      cnt   <= '0;
      div_q <= 1'b0;
      lo_q  <= '0;
      hi_q  <= '0;
      opb_q <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= CW'(WIDTH - 1);
      div_q <= is_div;
      lo_q  <= a;
      hi_q  <= '0;
      opb_q <= b;
    end else if (busy) begin
      lo_q <= lo;
      hi_q <= hi;
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Button-driven operand entry FSM around a WIDTH-bit ALU with iterative
// mul/div, status flags, busy/done handshake and optional result chaining.
module alu_sequencer import alu_seq_pkg::*; #(
  parameter int WIDTH = 8,
  parameter bit CHAIN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  input  logic [3:0]       selector,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] y_hi,
  output logic [4:0]       flags,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [3:0]       op_q;
  logic             s1, s2, s3, press;
  logic             go_iter, it_busy, it_last;
  logic [WIDTH-1:0] it_lo, it_hi;
  logic [WIDTH:0]   add_r, sub_r;
  logic             shift_big;
  logic [WIDTH-1:0] r_y, r_hi;
  logic [4:0]       r_f;

  // Synchronise the raw button and keep one extra stage for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= enable;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign press   = s2 & ~s3;
  assign go_iter = (state == S_EXEC) && is_iter_op(op_q) &&
                   !((op_q == OP_DIV) && (b_out == '0));

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clock  (clock),
    .reset  (reset),
    .start  (go_iter),
    .is_div (op_q == OP_DIV),
    .a      (a_out),
    .b      (b_out),
    .busy   (it_busy),
    .last   (it_last),
    .lo     (it_lo),
    .hi     (it_hi)
  );

  // Result and flags to be written; mul/div take the unit's final step.
  always_comb begin
    add_r     = {1'b0, a_out} + {1'b0, b_out};
    sub_r     = {1'b0, a_out} - {1'b0, b_out};
    shift_big = (b_out >= WIDTH'(WIDTH));
    r_y       = '0;
    r_hi      = '0;
    r_f       = '0;
    case (op_q)
      OP_ADD: begin
        r_y      = add_r[WIDTH-1:0];
        r_f[F_C] = add_r[WIDTH];
        r_f[F_V] = (a_out[WIDTH-1] == b_out[WIDTH-1]) &&
                   (add_r[WIDTH-1] != a_out[WIDTH-1]);
      end
      OP_SUB: begin
        r_y      = sub_r[WIDTH-1:0];
        r_f[F_C] = sub_r[WIDTH];
        r_f[F_V] = (a_out[WIDTH-1] != b_out[WIDTH-1]) &&
                   (sub_r[WIDTH-1] != a_out[WIDTH-1]);
      end
      OP_AND: r_y = a_out & b_out;
      OP_OR:  r_y = a_out | b_out;
      OP_XOR: r_y = a_out ^ b_out;
      OP_NOT: r_y = ~a_out;
      OP_SHL: r_y = shift_big ? '0 : (a_out << b_out);
      OP_SHR: r_y = shift_big ? '0 : (a_out >> b_out);
      OP_ASR: r_y = shift_big ? {WIDTH{a_out[WIDTH-1]}}
                              : $unsigned($signed(a_out) >>> b_out);
      OP_MUL: begin
        r_y      = it_lo;
        r_hi     = it_hi;
        r_f[F_C] = |it_hi;
      end
      OP_DIV: begin
        if (b_out == '0) begin
          r_y       = '1;
          r_hi      = a_out;
          r_f[F_DZ] = 1'b1;
        end else begin
          r_y  = it_lo;
          r_hi = it_hi;
        end
      end
      OP_SLT: r_y = {{(WIDTH-1){1'b0}}, ($signed(a_out) < $signed(b_out))};
      default: ;
    endcase
    // Illegal opcodes leave every flag clear, including Z.
    if (op_q <= OP_SLT) begin
      r_f[F_Z] = (r_y == '0);
      r_f[F_N] = r_y[WIDTH-1];
    end
  end

  // Operand entry / execute / show sequencer with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_LOAD_A;
      a_out <= '0;
      b_out <= '0;
      op_q  <= '0;
      y_out <= '0;
      y_hi  <= '0;
      flags <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_LOAD_A: if (press) begin
          a_out <= data_in;
          state <= S_LOAD_B;
        end
        S_LOAD_B: if (press) begin
          b_out <= data_in;
          op_q  <= selector;
          busy  <= 1'b1;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (go_iter) begin
            state <= S_ITER;
          end else begin
            y_out <= r_y;
            y_hi  <= r_hi;
            flags <= r_f;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_SHOW;
          end
        end
        // Finishing on an idle unit only guards against a lost handshake.
        S_ITER: if (it_last || !it_busy) begin
          y_out <= r_y;
          y_hi  <= r_hi;
          flags <= r_f;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_SHOW;
        end
        S_SHOW: if (press) begin
          if (CHAIN) begin
            a_out <= y_out;
            state <= S_LOAD_B;
          end else begin
            state <= S_LOAD_A;
          end
        end
        default: state <= S_LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer at WIDTH=8: a vector table of single
// operations plus hand sequences for chaining, held button and reset abort.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [3:0]   selector = '0;
  logic [W-1:0] a_out, b_out, y_out, y_hi;
  logic [4:0]   flags;
  logic         busy, done;
  logic [W-1:0] a0, b0, y0, h0;
  logic [4:0]   f0;
  logic         busy0, done0;

  always #5 clock = ~clock;

  alu_sequencer #(.WIDTH(W), .CHAIN(1'b1)) dut (
    .clock(clock), .reset(reset), .enable(enable), .data_in(data_in),
    .selector(selector), .a_out(a_out), .b_out(b_out), .y_out(y_out),
    .y_hi(y_hi), .flags(flags), .busy(busy), .done(done)
  );

  alu_sequencer #(.WIDTH(W), .CHAIN(1'b0)) dut0 (
    .clock(clock), .reset(reset), .enable(enable), .data_in(data_in),
    .selector(selector), .a_out(a0), .b_out(b0), .y_out(y0),
    .y_hi(h0), .flags(f0), .busy(busy0), .done(done0)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic [W-1:0] y;
    logic [W-1:0] hi;
    logic [4:0]   f;
    int           cyc;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // flags layout {DZ, N, V, C, Z}; busy spans EXEC plus 8 ITER cycles for mul/div
  function automatic vec_t mk(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                              input logic [3:0] op_i, input logic [W-1:0] y_i,
                              input logic [W-1:0] hi_i, input logic [4:0] f_i);
    vec_t v;
    v.a   = a_i;
    v.b   = b_i;
    v.op  = op_i;
    v.y   = y_i;
    v.hi  = hi_i;
    v.f   = f_i;
    v.cyc = ((op_i == OP_MUL) || ((op_i == OP_DIV) && (b_i != '0))) ? 1 + W : 1;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset  = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Returns on the negedge just after the capture edge (3 cycles after press).
  task automatic hit(input logic [W-1:0] v);
    @(negedge clock);
    data_in = v;
    enable  = 1'b1;
    repeat (3) @(negedge clock);
    enable = 1'b0;
  endtask

  task automatic press(input logic [W-1:0] v);
    hit(v);
    repeat (2) @(negedge clock);
  endtask

  // Called right after the B capture edge; bounded 20-cycle observation window.
  task automatic finish_op(input string tag, input int exp_busy, input bit poke);
    int nb    = 0;
    int nd    = 0;
    int first = -1;
    for (int i = 0; i < 20; i++) begin
      if (poke && i == 2) begin
        data_in = 8'h55;
        enable  = 1'b1;
      end
      if (poke && i == 7) enable = 1'b0;
      if (busy) nb++;
      if (done) begin
        nd++;
        if (first < 0) first = i;
      end
      @(negedge clock);
    end
    chk({tag, " busy cycles"}, nb, exp_busy);
    chk({tag, " done pulses"}, nd, 1);
    chk({tag, " done cycle"}, first, exp_busy);
  endtask

  initial begin
    int nd;
    vecs.push_back(mk(8'h7F, 8'h01, OP_ADD, 8'h80, 8'h00, 5'b01100));
    vecs.push_back(mk(8'h05, 8'h05, OP_SUB, 8'h00, 8'h00, 5'b00001));
    vecs.push_back(mk(8'h03, 8'h05, OP_SUB, 8'hFE, 8'h00, 5'b01010));
    vecs.push_back(mk(8'hFF, 8'hFF, OP_MUL, 8'h01, 8'hFE, 5'b00010));
    vecs.push_back(mk(8'd100, 8'd7, OP_DIV, 8'd14, 8'd2, 5'b00000));
    vecs.push_back(mk(8'd100, 8'd0, OP_DIV, 8'hFF, 8'd100, 5'b11000));
    vecs.push_back(mk(8'hFF, 8'd9, OP_SHL, 8'h00, 8'h00, 5'b00001));
    vecs.push_back(mk(8'h80, 8'd9, OP_ASR, 8'hFF, 8'h00, 5'b01000));
    vecs.push_back(mk(8'hF0, 8'h3C, OP_AND, 8'h30, 8'h00, 5'b00000));
    vecs.push_back(mk(8'hF0, 8'h0F, OP_OR,  8'hFF, 8'h00, 5'b01000));
    vecs.push_back(mk(8'hAA, 8'hFF, OP_XOR, 8'h55, 8'h00, 5'b00000));
    vecs.push_back(mk(8'h0F, 8'h33, OP_NOT, 8'hF0, 8'h00, 5'b01000));
    vecs.push_back(mk(8'h80, 8'd3, OP_SHR, 8'h10, 8'h00, 5'b00000));
    vecs.push_back(mk(8'h80, 8'd3, OP_ASR, 8'hF0, 8'h00, 5'b01000));
    vecs.push_back(mk(8'h01, 8'd7, OP_SHL, 8'h80, 8'h00, 5'b01000));
    vecs.push_back(mk(8'h01, 8'd8, OP_SHL, 8'h00, 8'h00, 5'b00001));
    vecs.push_back(mk(8'hFF, 8'h01, OP_SLT, 8'h01, 8'h00, 5'b00000));
    vecs.push_back(mk(8'h01, 8'hFF, OP_SLT, 8'h00, 8'h00, 5'b00001));
    vecs.push_back(mk(8'h05, 8'h05, 4'd13,  8'h00, 8'h00, 5'b00000));
    vecs.push_back(mk(8'hFF, 8'h01, OP_ADD, 8'h00, 8'h00, 5'b00011));
    vecs.push_back(mk(8'h10, 8'h10, OP_MUL, 8'h00, 8'h01, 5'b00011));
    vecs.push_back(mk(8'hFF, 8'h10, OP_DIV, 8'h0F, 8'h0F, 5'b00000));
    vecs.push_back(mk(8'h80, 8'h01, OP_SUB, 8'h7F, 8'h00, 5'b00100));

    // Reset state
    do_reset();
    @(negedge clock);
    chk("reset a/b/y/hi", {a_out, b_out, y_out, y_hi}, 32'h0);
    chk("reset flags", flags, 5'h0);
    chk("reset busy/done", {busy, done}, 2'b00);
    chk("reset state", dut.state, S_LOAD_A);

    // Table of single operations, each from a fresh reset
    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("v%0d", i);
      do_reset();
      press(vecs[i].a);
      selector = vecs[i].op;
      hit(vecs[i].b);
      finish_op(tag, vecs[i].cyc, vecs[i].op == OP_MUL);
      chk({tag, " y_out"}, y_out, vecs[i].y);
      chk({tag, " y_hi"}, y_hi, vecs[i].hi);
      chk({tag, " flags"}, flags, vecs[i].f);
      chk({tag, " a/b hold"}, {a_out, b_out}, {vecs[i].a, vecs[i].b});
      if (vecs[i].op == OP_MUL) chk({tag, " state after busy press"}, dut.state, S_SHOW);
    end

    // Chaining: CHAIN=1 reloads A from Y, CHAIN=0 returns to operand A entry
    do_reset();
    press(8'd3);
    selector = OP_ADD;
    hit(8'd4);
    finish_op("chain1", 1, 1'b0);
    chk("chain1 y_out", y_out, 8'd7);
    press(8'h99);
    chk("chain a_out", a_out, 8'd7);
    chk("chain state", dut.state, S_LOAD_B);
    chk("nochain state", dut0.state, S_LOAD_A);
    chk("nochain a_out", a0, 8'd3);
    selector = OP_ADD;
    hit(8'd1);
    finish_op("chain2", 1, 1'b0);
    chk("chain2 y_out", y_out, 8'd8);
    chk("nochain new A", a0, 8'd1);

    // Reset in the middle of an iterative multiply
    press(8'h22);
    chk("chain3 a_out", a_out, 8'd8);
    selector = OP_MUL;
    hit(8'd3);
    repeat (3) @(negedge clock);
    chk("mid-iter busy", busy, 1'b1);
    chk("mid-iter state", dut.state, S_ITER);
    reset = 1'b1;
    @(negedge clock);
    chk("abort a/b/y/hi", {a_out, b_out, y_out, y_hi}, 32'h0);
    chk("abort flags/busy/done", {flags, busy, done}, 7'h0);
    chk("abort state", dut.state, S_LOAD_A);
    chk("abort nochain outs", {b0, y0, h0, f0, busy0, done0}, 31'h0);
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) nd++;
      @(negedge clock);
    end
    chk("abort no done", nd, 0);

    // Button held for 50 cycles captures once
    do_reset();
    @(negedge clock);
    data_in = 8'h11;
    enable  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) data_in = 8'h22;
      @(negedge clock);
    end
    enable = 1'b0;
    repeat (3) @(negedge clock);
    chk("held a_out", a_out, 8'h11);
    chk("held b_out", b_out, 8'h00);
    chk("held state", dut.state, S_LOAD_B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
